// File: rtl/channel_sampler_gen.sv
`default_nettype none
// ============================================================================
// channel_sampler_gen : per-channel synchroniser, DEPTH-tap history, packed
//                       sample words on a valid/ready handshake (pack/stream).
// Revision 1.0
// ============================================================================
module channel_sampler_gen #(
  parameter int NUM_CH      = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_in,
  input  logic                     smpl_en,
  input  logic                     pack_mode,
  input  logic                     smpl_rdy,
  input  logic                     ovr_clr,
  output logic [NUM_CH*DEPTH-1:0]  smpl,
  output logic                     smpl_vld,
  output logic [NUM_CH-1:0]        ch_last,
  output logic                     chg,
  output logic                     ovr
);

  localparam int C_FILL_W = $clog2(DEPTH + 1);
  localparam int C_GRP_W  = $clog2(DEPTH);
  localparam int C_WORD_W = NUM_CH * DEPTH;

  localparam logic [C_FILL_W-1:0] C_FILL_MAX = C_FILL_W'(DEPTH);
  localparam logic [C_FILL_W-1:0] C_FILL_CAP = C_FILL_W'(DEPTH - 1);
  localparam logic [C_FILL_W-1:0] C_FILL_ONE = C_FILL_W'(1);
  localparam logic [C_GRP_W-1:0]  C_GRP_LAST = C_GRP_W'(DEPTH - 1);
  localparam logic [C_GRP_W-1:0]  C_GRP_ONE  = C_GRP_W'(1);

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
  logic [DEPTH-1:0][NUM_CH-1:0]       tap_q, tap_d;
  logic [C_FILL_W-1:0]                fill_q, fill_d;
  logic [C_GRP_W-1:0]                 grp_q, grp_d;
  logic                               mode_q, mode_d;
  logic [C_WORD_W-1:0]                smpl_q, smpl_d;
  logic                               vld_q, vld_d;
  logic                               chg_q, chg_d;
  logic                               ovr_q, ovr_d;

  logic [NUM_CH-1:0]   w_sync_out;
  logic [C_WORD_W-1:0] w_word;
  logic                w_mode_chg;
  logic [C_GRP_W-1:0]  w_grp_eff;
  logic                w_cap;
  logic                w_load;
  logic                w_drop;

  assign w_sync_out = sync_q[SYNC_STAGES-1];

  // Newest tap lands in the MSBs of the word, built from next-state taps.
  for (genvar k = 0; k < DEPTH; k++) begin : g_pack
    assign w_word[NUM_CH*(DEPTH-1-k) +: NUM_CH] = tap_d[k];
  end

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ch_in};
    tap_d  = tap_q;
    if (smpl_en) begin
      tap_d = {tap_q[DEPTH-2:0], w_sync_out};
    end
  end

  // A mode change restarts the packing group; the new mode decides the capture.
  always_comb begin
    mode_d     = pack_mode;
    w_mode_chg = pack_mode ^ mode_q;
    w_grp_eff  = w_mode_chg ? '0 : grp_q;
    w_cap      = smpl_en && (fill_q >= C_FILL_CAP) &&
                 (!pack_mode || (w_grp_eff == C_GRP_LAST));

    fill_d = fill_q;
    if (smpl_en && (fill_q != C_FILL_MAX)) begin
      fill_d = fill_q + C_FILL_ONE;
    end

    grp_d = grp_q;
    if (w_mode_chg) begin
      grp_d = '0;
    end else if (smpl_en) begin
      grp_d = (grp_q == C_GRP_LAST) ? '0 : grp_q + C_GRP_ONE;
    end
  end

  always_comb begin
    w_load = w_cap && (!vld_q || smpl_rdy);
    w_drop = w_cap && vld_q && !smpl_rdy;

    smpl_d = smpl_q;
    vld_d  = vld_q;
    if (w_load) begin
      smpl_d = w_word;
      vld_d  = 1'b1;
    end else if (vld_q && smpl_rdy) begin
      vld_d = 1'b0;
    end

    ovr_d = w_drop || (ovr_q && !ovr_clr);
    chg_d = smpl_en && (w_sync_out != tap_q[0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      tap_q  <= '0;
      fill_q <= '0;
      grp_q  <= '0;
      mode_q <= 1'b0;
      smpl_q <= '0;
      vld_q  <= 1'b0;
      chg_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      tap_q  <= tap_d;
      fill_q <= fill_d;
      grp_q  <= grp_d;
      mode_q <= mode_d;
      smpl_q <= smpl_d;
      vld_q  <= vld_d;
      chg_q  <= chg_d;
      ovr_q  <= ovr_d;
    end
  end

  assign smpl     = smpl_q;
  assign smpl_vld = vld_q;
  assign ch_last  = tap_q[DEPTH-1];
  assign chg      = chg_q;
  assign ovr      = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_channel_sampler_gen.sv
`default_nettype none
// ============================================================================
// tb_channel_sampler_gen : scoreboard bench for channel_sampler_gen (2ch x 4).
// Revision 1.0
// ============================================================================
module tb_channel_sampler_gen;

  localparam int NC = 2;
  localparam int DP = 4;
  localparam int SS = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NC-1:0]     ch_in = '0;
  logic              smpl_en = 1'b0;
  logic              pack_mode = 1'b0;
  logic              smpl_rdy = 1'b0;
  logic              ovr_clr = 1'b0;
  logic [NC*DP-1:0]  smpl;
  logic              smpl_vld;
  logic [NC-1:0]     ch_last;
  logic              chg;
  logic              ovr;

  always #5 clk = ~clk;

  channel_sampler_gen #(
    .NUM_CH      (NC),
    .DEPTH       (DP),
    .SYNC_STAGES (SS)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .ch_in     (ch_in),
    .smpl_en   (smpl_en),
    .pack_mode (pack_mode),
    .smpl_rdy  (smpl_rdy),
    .ovr_clr   (ovr_clr),
    .smpl      (smpl),
    .smpl_vld  (smpl_vld),
    .ch_last   (ch_last),
    .chg       (chg),
    .ovr       (ovr)
  );

  int total = 0;
  int bad   = 0;
  logic [NC*DP-1:0] exp_q[$];

  // Sample-level reference model of the sampler, stepped once per clock.
  logic [NC-1:0]    m_sync[SS];
  logic [NC-1:0]    m_tap[DP];
  int               m_fill;
  int               m_grp;
  logic             m_mode;
  logic             m_vld;
  logic             m_ovr;
  logic             m_chg;
  logic [NC*DP-1:0] m_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SS; s++) m_sync[s] = '0;
    for (int k = 0; k < DP; k++) m_tap[k] = '0;
    m_fill = 0;
    m_grp  = 0;
    m_mode = 1'b0;
    m_vld  = 1'b0;
    m_ovr  = 1'b0;
    m_chg  = 1'b0;
    m_word = '0;
    exp_q.delete();
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cyc();
    logic [NC-1:0]    so;
    logic             mism;
    logic             cap;
    logic             drop;
    int               g;
    logic [NC*DP-1:0] w;
    logic [NC*DP-1:0] e;

    chk("vld", 32'(smpl_vld), 32'(m_vld));
    chk("ovr", 32'(ovr), 32'(m_ovr));
    chk("chg", 32'(chg), 32'(m_chg));
    chk("ch_last", 32'(ch_last), 32'(m_tap[DP-1]));
    if (m_vld) chk("smpl_hold", 32'(smpl), 32'(m_word));
    if (smpl_vld && smpl_rdy) begin
      chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_word", 32'(smpl), 32'(e));
      end
    end

    so   = m_sync[SS-1];
    mism = (pack_mode != m_mode);
    g    = mism ? 0 : m_grp;
    cap  = smpl_en && (m_fill >= DP - 1) && (!pack_mode || g == DP - 1);
    drop = cap && m_vld && !smpl_rdy;
    m_chg = smpl_en && (so != m_tap[0]);
    if (smpl_en) begin
      for (int k = DP - 1; k > 0; k--) m_tap[k] = m_tap[k-1];
      m_tap[0] = so;
      if (m_fill < DP) m_fill++;
    end
    if (mism) m_grp = 0;
    else if (smpl_en) m_grp = (g + 1) % DP;
    w = '0;
    for (int k = 0; k < DP; k++)
      for (int c = 0; c < NC; c++)
        w[NC*(DP-1-k)+c] = m_tap[k][c];
    if (cap && (!m_vld || smpl_rdy)) begin
      m_word = w;
      m_vld  = 1'b1;
      exp_q.push_back(w);
    end else if (!cap && m_vld && smpl_rdy) begin
      m_vld = 1'b0;
    end
    if (drop) m_ovr = 1'b1;
    else if (ovr_clr) m_ovr = 1'b0;
    for (int s = SS - 1; s > 0; s--) m_sync[s] = m_sync[s-1];
    m_sync[0] = ch_in;
    m_mode = pack_mode;

    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold v past the synchroniser, then one smpl_en strobe.
  task automatic tick(input logic [NC-1:0] v, input logic rdy_idle, input logic rdy_tick);
    ch_in    = v;
    smpl_en  = 1'b0;
    smpl_rdy = rdy_idle;
    for (int i = 0; i < SS + 1; i++) begin
      cyc();
      chk("chg_idle", 32'(chg), 0);
    end
    smpl_en  = 1'b1;
    smpl_rdy = rdy_tick;
    cyc();
    smpl_en  = 1'b0;
    smpl_rdy = rdy_idle;
  endtask

  // Asynchronous reset, checked mid-cycle before any clock edge.
  task automatic do_reset(input logic mode);
    #2 rst = 1'b1;
    #1;
    chk("rst_smpl", 32'(smpl), 0);
    chk("rst_vld", 32'(smpl_vld), 0);
    chk("rst_ch_last", 32'(ch_last), 0);
    chk("rst_chg", 32'(chg), 0);
    chk("rst_ovr", 32'(ovr), 0);
    model_reset();
    ch_in     = '0;
    smpl_en   = 1'b0;
    smpl_rdy  = 1'b0;
    ovr_clr   = 1'b0;
    pack_mode = mode;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk);

    // Pack mode, basic word.
    do_reset(1'b1);
    tick(2'b10, 1'b1, 1'b1);
    tick(2'b01, 1'b1, 1'b1);
    tick(2'b11, 1'b1, 1'b1);
    tick(2'b00, 1'b1, 1'b1);
    chk("pack_word", 32'(smpl), 'h36);
    chk("pack_vld", 32'(smpl_vld), 1);
    chk("pack_last", 32'(ch_last), 'h2);
    cyc();
    chk("pack_vld_drop", 32'(smpl_vld), 0);

    // Change detect.
    do_reset(1'b1);
    tick(2'b11, 1'b1, 1'b1);
    chk("chg_t1", 32'(chg), 1);
    tick(2'b11, 1'b1, 1'b1);
    chk("chg_t2", 32'(chg), 0);
    tick(2'b11, 1'b1, 1'b1);
    chk("chg_t3", 32'(chg), 0);
    tick(2'b01, 1'b1, 1'b1);
    chk("chg_t4", 32'(chg), 1);
    chk("chg_word", 32'(smpl), 'h7f);
    cyc();

    // Stream mode, strobe tied high.
    do_reset(1'b0);
    smpl_rdy = 1'b1;
    ch_in = 2'b01;
    cyc();
    ch_in = 2'b10;
    cyc();
    smpl_en = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      ch_in = (j % 2 == 1) ? 2'b01 : 2'b10;
      cyc();
      if (j < DP) begin
        chk("strm_vld_pre", 32'(smpl_vld), 0);
      end else begin
        chk("strm_vld", 32'(smpl_vld), 1);
        chk("strm_word", 32'(smpl), (j % 2 == 0) ? 'h99 : 'h66);
      end
    end
    smpl_en = 1'b0;
    cyc();

    // Overrun across two groups.
    do_reset(1'b1);
    tick(2'b01, 1'b0, 1'b0);
    tick(2'b10, 1'b0, 1'b0);
    tick(2'b11, 1'b0, 1'b0);
    tick(2'b00, 1'b0, 1'b0);
    tick(2'b11, 1'b0, 1'b0);
    tick(2'b11, 1'b0, 1'b0);
    tick(2'b00, 1'b0, 1'b0);
    tick(2'b01, 1'b0, 1'b0);
    chk("ovr_word", 32'(smpl), 'h39);
    chk("ovr_vld", 32'(smpl_vld), 1);
    chk("ovr_set", 32'(ovr), 1);
    ovr_clr = 1'b1;
    cyc();
    ovr_clr = 1'b0;
    chk("ovr_clr", 32'(ovr), 0);
    smpl_rdy = 1'b1;
    cyc();
    chk("ovr_accept", 32'(smpl_vld), 0);

    // Accept and capture on the same edge.
    tick(2'b10, 1'b0, 1'b0);
    tick(2'b10, 1'b0, 1'b0);
    tick(2'b01, 1'b0, 1'b0);
    tick(2'b11, 1'b0, 1'b0);
    chk("g3_word", 32'(smpl), 'hda);
    tick(2'b00, 1'b0, 1'b0);
    tick(2'b01, 1'b0, 1'b0);
    tick(2'b10, 1'b0, 1'b0);
    tick(2'b11, 1'b0, 1'b1);
    chk("swap_word", 32'(smpl), 'he4);
    chk("swap_vld", 32'(smpl_vld), 1);
    chk("swap_ovr", 32'(ovr), 0);
    smpl_rdy = 1'b1;
    cyc();
    chk("swap_accept", 32'(smpl_vld), 0);

    // Reset in the middle of a group with a word pending.
    do_reset(1'b1);
    tick(2'b01, 1'b0, 1'b0);
    tick(2'b10, 1'b0, 1'b0);
    tick(2'b11, 1'b0, 1'b0);
    tick(2'b00, 1'b0, 1'b0);
    tick(2'b11, 1'b0, 1'b0);
    tick(2'b11, 1'b0, 1'b0);
    chk("pre_rst_vld", 32'(smpl_vld), 1);
    do_reset(1'b1);
    tick(2'b10, 1'b1, 1'b1);
    chk("post_rst_t1", 32'(smpl_vld), 0);
    tick(2'b01, 1'b1, 1'b1);
    chk("post_rst_t2", 32'(smpl_vld), 0);
    tick(2'b11, 1'b1, 1'b1);
    chk("post_rst_t3", 32'(smpl_vld), 0);
    tick(2'b00, 1'b1, 1'b1);
    chk("post_rst_word", 32'(smpl), 'h36);
    chk("post_rst_vld", 32'(smpl_vld), 1);
    cyc();
    cyc();
    chk("sb_drain", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/channel_sampler_gen.md
Name: channel_sampler_gen

Overview:
- Parametrised multi-channel sampler; successor to the fixed 2-channel, 4-deep sampler.
- Runs entirely on the system clock. The decimated sample rate is a one-cycle enable strobe, not a second clock.
- Synchronises NUM_CH raw channel inputs and keeps a DEPTH-deep per-channel history. Emits packed sample words to the capture/trigger logic through a valid/ready handshake.
- Adds: pack vs stream capture modes, change detect, and a sticky overrun flag.

Parameters:
NUM_CH, 2, number of input channels (>=1)
DEPTH, 4, sample history taps per channel, also samples per packed word (>=2)
SYNC_STAGES, 2, metastability synchroniser flops per channel (>=2)

Ports:
clk  input  1  system clock; all flops on posedge
rst  input  1  asynchronous active-high reset
ch_in  input  NUM_CH  raw channel inputs, asynchronous to clk
smpl_en  input  1  sample tick, one clk wide, at 400MHz/2^decimator equivalent rate
pack_mode  input  1  1 = pack (one word per DEPTH samples), 0 = stream (one word per sample)
smpl_rdy  input  1  consumer accepts smpl when smpl_vld & smpl_rdy at posedge
ovr_clr  input  1  clears ovr
smpl  output  NUM_CH*DEPTH  packed sample word
smpl_vld  output  1  smpl holds an unaccepted word
ch_last  output  NUM_CH  oldest history tap, tap[DEPTH-1], for trigger logic
chg  output  1  one-cycle pulse: newest sample differs from previous sample
ovr  output  1  sticky: a capture was dropped

Behaviour:
- Reset: every flop clears asynchronously. smpl=0, smpl_vld=0, ch_last=0, chg=0, ovr=0. Synchroniser, taps, fill counter and group counter also clear.
- Reset asserted mid-operation discards any pending word and any partial group.
- Synchroniser: SYNC_STAGES flops per channel, clocked every clk regardless of smpl_en. sync_out is the last stage.
- History: tap[0..DEPTH-1], each NUM_CH wide. Advances only on clk edges with smpl_en=1: tap[0]<=sync_out, tap[k]<=tap[k-1]. ch_last = tap[DEPTH-1].
- Packing: smpl[NUM_CH*(DEPTH-1-k)+c] = tap[k][c], so the newest sample occupies the MSBs.
- smpl is loaded from the post-shift tap values, which are the next-state values. It updates on the same edge that shifts in the completing sample; no added latency.
- Input-to-tap[0] latency: SYNC_STAGES clk edges, then the next smpl_en edge.
- fill counter:
  - 0..DEPTH, saturating, increments on each smpl_en.
  - No capture is possible until fill reaches DEPTH. In pack mode this condition is met automatically by group completion.
- group counter: 0..DEPTH-1, increments on each smpl_en and wraps DEPTH-1 -> 0.
- Capture event, evaluated on an edge with smpl_en=1:
  - pack mode: group counter == DEPTH-1 before the increment.
  - stream mode: fill >= DEPTH-1 before the increment.
- pack_mode change: a registered copy of pack_mode is compared each cycle. On a mismatch, the group counter is forced to 0 that edge and taps keep shifting. If smpl_en falls on that same edge, the new mode governs the capture decision.
- Handshake:
  - Capture with smpl_vld=0: load smpl, set smpl_vld=1.
  - smpl_vld & smpl_rdy with no capture: clear smpl_vld.
  - Capture together with smpl_vld & smpl_rdy: load the new word, smpl_vld stays 1, no overrun.
  - Capture with smpl_vld=1 & smpl_rdy=0: drop the new word, smpl held stable, set ovr.
- smpl is stable whenever smpl_vld=1 and no accepted-capture occurs.
- ovr: set by a dropped capture, cleared by ovr_clr. If set and clear coincide, set wins.
- chg: on an edge with smpl_en=1, chg <= (sync_out != tap[0]); otherwise chg <= 0. The first sample after reset compares against 0.

Test Plan:
- NUM_CH=2, DEPTH=4, pack_mode=1, smpl_rdy=1. Apply ch_in 2'b10, 01, 11, 00 on four successive smpl_en ticks, each held past the sync latency. Expect smpl=8'h36 with smpl_vld=1 for one cycle right after the 4th tick; ch_last=2'b10.
- Stream mode, smpl_en tied high, ch_in toggling 2'b01/2'b10 each tick. Expect no smpl_vld during the first 3 ticks, then smpl_vld=1 on every cycle, with smpl alternating 8'h66/8'h99.
- Pack mode, smpl_rdy=0 across two groups. Expect smpl holds the first word, smpl_vld=1, ovr=1 after the 8th tick. Pulse ovr_clr -> ovr=0; raise smpl_rdy -> smpl_vld=0 the next cycle.
- smpl_rdy=1 on exactly the edge that completes the next group while smpl_vld=1. Expect the new word loaded, smpl_vld stays 1, ovr stays 0.
- ch_in steady 2'b11 for 3 ticks, then 2'b01. Expect chg=1 on the first tick (vs reset 0), 0 on ticks 2-3, and 1 on the change tick; chg is never high on non-tick cycles.
- Assert rst mid-group (after 2 ticks) with smpl_vld=1. Expect every output 0 immediately, asynchronously. After release, the first word appears only after 4 new ticks.
